// File: rtl/dunit_pkg.sv
// rtl/dunit_pkg.sv - shared command codes, state encoding and helpers for debug_unit
package dunit_pkg;

  localparam logic [7:0] CMD_LOAD  = 8'h4C;
  localparam logic [7:0] CMD_RUN   = 8'h43;
  localparam logic [7:0] CMD_STEP  = 8'h53;
  localparam logic [7:0] CMD_RSTPC = 8'h52;
  localparam logic [7:0] ACK_BYTE  = 8'h4B;

  localparam int NUM_REGS = 32;

  typedef enum logic [3:0] {
    IDLE,
    LOAD_CNT,
    LOAD_BYTE,
    LOAD_WR,
    RSTPC,
    RUN,
    STEP,
    DUMP_SET,
    DUMP_CAP,
    DUMP_SEND,
    ACK
  } state_t;

  // Byte address of a 32-bit word index.
  function automatic logic [31:0] word_addr(input logic [7:0] k);
    return {22'd0, k, 2'b00};
  endfunction

endpackage

// File: rtl/debug_unit_if.sv
// rtl/debug_unit_if.sv - UART byte stream and pipeline debug port bundle for debug_unit
interface debug_unit_if #(
  parameter int NB_REG  = 32,
  parameter int NB_BYTE = 8
);
  logic [NB_BYTE-1:0] i_rx_data;
  logic               i_rx_valid;
  logic               i_tx_done;
  logic [NB_BYTE-1:0] o_tx_data;
  logic               o_tx_start;
  logic               i_halt;
  logic [NB_REG-1:0]  i_dunit_reg;
  logic [NB_REG-1:0]  i_dunit_mem_data;
  logic               o_dunit_clk_en;
  logic               o_dunit_reset_pc;
  logic               o_dunit_w_mem;
  logic [NB_REG-1:0]  o_dunit_addr;
  logic [NB_REG-1:0]  o_dunit_data;
  logic               o_busy;

  modport master (
    input  i_rx_data, i_rx_valid, i_tx_done, i_halt, i_dunit_reg, i_dunit_mem_data,
    output o_tx_data, o_tx_start, o_dunit_clk_en, o_dunit_reset_pc, o_dunit_w_mem,
           o_dunit_addr, o_dunit_data, o_busy
  );

  modport slave (
    output i_rx_data, i_rx_valid, i_tx_done, i_halt, i_dunit_reg, i_dunit_mem_data,
    input  o_tx_data, o_tx_start, o_dunit_clk_en, o_dunit_reset_pc, o_dunit_w_mem,
           o_dunit_addr, o_dunit_data, o_busy
  );
endinterface

// File: rtl/dunit_word_tx.sv
// rtl/dunit_word_tx.sv - serializes one word MSB byte first over the tx start/done handshake
module dunit_word_tx #(
  parameter int NB_REG  = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_REG-1:0]  i_word,
  input  logic               i_start,
  input  logic               i_one_byte,
  input  logic               i_tx_done,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_done
);
  localparam int NB_CNT = $clog2(NB_REG / NB_BYTE);
  localparam logic [NB_CNT-1:0] LAST = NB_CNT'(NB_REG / NB_BYTE - 1);

  logic [NB_REG-1:0] word_q;
  logic [NB_CNT-1:0] cnt;
  logic              pending;
  logic              start_q;
  logic              done_q;

  // A single-byte send starts at the last slot so the first done finishes it.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      word_q  <= '0;
      cnt     <= '0;
      pending <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      if (i_start && !pending) begin
        word_q  <= i_word;
        cnt     <= i_one_byte ? LAST : '0;
        pending <= 1'b1;
        start_q <= 1'b1;
      end else if (pending && i_tx_done) begin
        if (cnt == LAST) begin
          pending <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          cnt     <= cnt + 1'b1;
          word_q  <= {word_q[NB_REG-NB_BYTE-1:0], {NB_BYTE{1'b0}}};
          start_q <= 1'b1;
        end
      end
    end
  end

  assign o_tx_data  = word_q[NB_REG-1 -: NB_BYTE];
  assign o_tx_start = start_q;
  assign o_done     = done_q;

endmodule

// File: rtl/debug_unit.sv
// rtl/debug_unit.sv - UART-driven pipeline debug controller (load/run/step/dump); option DUNIT_CYCLE_COUNT_EN
module debug_unit
  import dunit_pkg::*;
#(
  parameter int NB_REG     = 32,
  parameter int NB_BYTE    = 8,
  parameter int NB_ADDR    = 5,
  parameter int MAX_INST   = 128,
  parameter int DUMP_WORDS = 32
) (
  input  logic         i_clk,
  input  logic         i_reset,
  debug_unit_if.master bus
);
`ifdef DUNIT_CYCLE_COUNT_EN
  localparam int DUMP_ITEMS = NUM_REGS + DUMP_WORDS + 1;
`else
  localparam int DUMP_ITEMS = NUM_REGS + DUMP_WORDS;
`endif
  localparam int NB_DIDX = $clog2(DUMP_ITEMS + 1);
  localparam logic [NB_DIDX-1:0] DUMP_LAST = NB_DIDX'(DUMP_ITEMS - 1);

  state_t               state, state_nxt;
  logic [7:0]           word_cnt;
  logic [7:0]           word_idx;
  logic [1:0]           byte_cnt;
  logic [NB_REG-1:0]    data_q;
  logic [NB_REG-1:0]    addr_q;
  logic [NB_DIDX-1:0]   dump_idx;
  logic [NB_DIDX-1:0]   dump_idx_nxt;
  logic [NB_REG-1:0]    dump_word;
  logic [NB_REG-1:0]    wt_word;
  logic                 wt_start;
  logic                 wt_one_byte;
  logic                 wt_done;
  logic                 clk_en;
  logic [NB_BYTE-1:0]   rx;

  assign rx = bus.i_rx_data;

  // Register items use the plain index; memory items use byte addresses from 0.
  function automatic logic [NB_REG-1:0] dump_addr(input logic [NB_DIDX-1:0] idx);
    if (int'(idx) < NUM_REGS) return NB_REG'(idx[NB_ADDR-1:0]);
    return word_addr(8'(idx - NB_DIDX'(NUM_REGS)));
  endfunction

`ifdef DUNIT_CYCLE_COUNT_EN
  logic [31:0] cyc_cnt;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cyc_cnt <= '0;
    end else if (state == IDLE && bus.i_rx_valid && (rx == CMD_RUN || rx == CMD_STEP)) begin
      cyc_cnt <= '0;
    end else if (clk_en && cyc_cnt != 32'hFFFF_FFFF) begin
      cyc_cnt <= cyc_cnt + 32'd1;
    end
  end
`endif

  always_comb begin
    dump_word = bus.i_dunit_mem_data;
    if (int'(dump_idx) < NUM_REGS) begin
      dump_word = bus.i_dunit_reg;
    end
`ifdef DUNIT_CYCLE_COUNT_EN
    else if (dump_idx == DUMP_LAST) begin
      dump_word = cyc_cnt;
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    wt_start     = 1'b0;
    wt_one_byte  = 1'b0;
    wt_word      = dump_word;
    dump_idx_nxt = (state == DUMP_SEND) ? dump_idx + 1'b1 : '0;
    case (state)
      IDLE: begin
        if (bus.i_rx_valid) begin
          case (rx)
            CMD_LOAD:  state_nxt = LOAD_CNT;
            CMD_RSTPC: state_nxt = RSTPC;
            CMD_RUN:   state_nxt = RUN;
            CMD_STEP:  state_nxt = STEP;
            default:   state_nxt = IDLE;
          endcase
        end
      end
      LOAD_CNT:  if (bus.i_rx_valid) state_nxt = (rx == '0) ? ACK : LOAD_BYTE;
      LOAD_BYTE: if (bus.i_rx_valid && byte_cnt == 2'd3) state_nxt = LOAD_WR;
      LOAD_WR:   state_nxt = (({1'b0, word_idx} + 9'd1) == {1'b0, word_cnt}) ? ACK : LOAD_BYTE;
      RSTPC:     state_nxt = ACK;
      RUN:       if (bus.i_halt) state_nxt = DUMP_SET;
      STEP:      state_nxt = DUMP_SET;
      DUMP_SET:  state_nxt = DUMP_CAP;
      DUMP_CAP: begin
        wt_start  = 1'b1;
        state_nxt = DUMP_SEND;
      end
      DUMP_SEND: if (wt_done) state_nxt = (dump_idx == DUMP_LAST) ? IDLE : DUMP_SET;
      ACK:       if (wt_done) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    // The acknowledge byte is launched on the transition into ACK.
    if (state_nxt == ACK && state != ACK) begin
      wt_start    = 1'b1;
      wt_one_byte = 1'b1;
      wt_word     = {ACK_BYTE, {(NB_REG - 8){1'b0}}};
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      word_cnt <= '0;
      word_idx <= '0;
      byte_cnt <= '0;
      data_q   <= '0;
      addr_q   <= '0;
      dump_idx <= '0;
    end else begin
      case (state)
        LOAD_CNT: begin
          if (bus.i_rx_valid) begin
            word_cnt <= rx;
            word_idx <= '0;
            byte_cnt <= '0;
          end
        end
        LOAD_BYTE: begin
          if (bus.i_rx_valid) begin
            data_q   <= {data_q[NB_REG-NB_BYTE-1:0], rx};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) addr_q <= word_addr(word_idx);
          end
        end
        LOAD_WR: word_idx <= word_idx + 8'd1;
        default: ;
      endcase
      if (state_nxt == DUMP_SET) begin
        dump_idx <= dump_idx_nxt;
        addr_q   <= dump_addr(dump_idx_nxt);
      end
    end
  end

  // Combinational so the pipeline never advances in the cycle halt is seen.
  assign clk_en = (state == RUN && !bus.i_halt) || (state == STEP);

  assign bus.o_dunit_clk_en   = clk_en;
  assign bus.o_dunit_reset_pc = (state == RSTPC);
  assign bus.o_dunit_w_mem    = (state == LOAD_WR) && (int'(word_idx) < MAX_INST);
  assign bus.o_dunit_addr     = addr_q;
  assign bus.o_dunit_data     = data_q;
  assign bus.o_busy           = (state != IDLE);

  dunit_word_tx #(
    .NB_REG  (NB_REG),
    .NB_BYTE (NB_BYTE)
  ) u_word_tx (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_word     (wt_word),
    .i_start    (wt_start),
    .i_one_byte (wt_one_byte),
    .i_tx_done  (bus.i_tx_done),
    .o_tx_data  (bus.o_tx_data),
    .o_tx_start (bus.o_tx_start),
    .o_done     (wt_done)
  );

endmodule

// File: doc/debug_unit.md
Name: debug_unit

Overview:
- Host-side controller driving the pipeline's debug port over a byte stream from an external UART receiver/transmitter pair.
- Loads programs into instruction memory, resets the PC, and runs the pipeline continuously or single-steps it.
- After each run or step, streams back the register file and the data-memory window.
- Sits between uart_rx/uart_tx and the pipeline top; it is the initiator for every pipeline i_dunit_* input and the consumer of o_dunit_reg, o_dunit_mem_data and o_halt.

Parameters:
- NB_REG, 32, data word width; instruction, register and memory word width.
- NB_BYTE, 8, UART byte width.
- NB_ADDR, 5, register index width.
- MAX_INST, 128, instruction-memory capacity in words (512 bytes).
- DUMP_WORDS, 32, data-memory words returned per dump, from byte address 0.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_rx_data  in  NB_BYTE  received byte.
- i_rx_valid  in  1  one-cycle pulse; i_rx_data is valid.
- i_tx_done  in  1  one-cycle pulse; transmitter has finished the current byte.
- o_tx_data  out  NB_BYTE  byte to transmit.
- o_tx_start  out  1  one-cycle transmit request.
- i_halt  in  1  pipeline o_halt.
- i_dunit_reg  in  NB_REG  register read data.
- i_dunit_mem_data  in  NB_REG  data-memory read data.
- o_dunit_clk_en  out  1  pipeline clock enable.
- o_dunit_reset_pc  out  1  PC reset pulse.
- o_dunit_w_mem  out  1  instruction-memory write strobe.
- o_dunit_addr  out  NB_REG  shared register, data-memory and instruction-memory address.
- o_dunit_data  out  NB_REG  instruction-memory write word.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (i_reset low, asynchronous, any state, including mid-load or mid-dump):
  - State returns to IDLE; all counters and the byte assembler clear.
  - All outputs are 0, so the pipeline is frozen.
- Commands are accepted only in IDLE. Unknown bytes are ignored. Bytes arriving outside IDLE/LOAD_CNT/LOAD_BYTE are dropped.
- 'L' (0x4C), load program:
  - LOAD_CNT: next byte is the word count N.
  - LOAD_BYTE: 4*N bytes follow, big-endian, assembled into o_dunit_data.
  - LOAD_WR: after the 4th byte, o_dunit_w_mem is high for exactly 1 cycle with o_dunit_addr = 4*k (k = word index from 0).
  - Words with k >= MAX_INST are assembled but not written.
  - N = 0: no write.
  - Completion: send ACK byte 0x4B, return to IDLE.
- 'R' (0x52), PC reset: o_dunit_reset_pc high for 1 cycle, send ACK 0x4B, return to IDLE.
- 'C' (0x43), run: RUN state. o_dunit_clk_en = (state==RUN) & ~i_halt, combinational, so no cycle executes after halt is seen. On i_halt high, go to DUMP. If i_halt is already high on entry, zero cycles execute.
- 'S' (0x53), step: o_dunit_clk_en high for exactly 1 cycle regardless of i_halt, then DUMP.
- DUMP:
  - For idx 0..31: DUMP_SET drives o_dunit_addr = idx; i_dunit_reg is captured 1 cycle later; the word is serialized.
  - Then for w 0..DUMP_WORDS-1: o_dunit_addr = 4*w; i_dunit_mem_data is captured 1 cycle later; the word is serialized.
  - Total bytes = 4*(32+DUMP_WORDS), then IDLE.
  - o_dunit_clk_en stays 0 throughout DUMP.
- Transmit handshake:
  - o_tx_start is a 1-cycle pulse with o_tx_data stable until i_tx_done.
  - The next byte is issued no earlier than the cycle after i_tx_done.
  - Words go out MSB byte first.
  - An i_tx_done seen without an outstanding start is ignored.
- o_dunit_addr holds its last value when idle; it is 0 after reset.

Optional Feature:
- Macro DUNIT_CYCLE_COUNT_EN.
- Defined: a 32-bit counter clears on 'C'/'S' entry and increments on every cycle with o_dunit_clk_en high, saturating at 0xFFFFFFFF. Its value is sent as 4 extra bytes, MSB first, after the memory dump.
- Undefined: no counter, and the dump length is exactly 4*(32+DUMP_WORDS).

Decomposition:
- dunit_pkg holds:
  - command codes CMD_LOAD/CMD_RUN/CMD_STEP/CMD_RSTPC and ACK_BYTE;
  - the state encoding (IDLE, LOAD_CNT, LOAD_BYTE, LOAD_WR, RSTPC, RUN, STEP, DUMP_SET, DUMP_CAP, DUMP_SEND, ACK);
  - NUM_REGS = 32.
- One sub-module, dunit_word_tx:
  - takes a 32-bit word plus a start strobe;
  - issues 4 byte transfers on the tx handshake;
  - pulses done when the last i_tx_done arrives.

Test Plan:
- 'L',0x02,0x20,0x01,0x00,0x05,0xFC,0x00,0x00,0x00 -> w_mem pulses at addr 0 data 0x20010005, then addr 4 data 0xFC000000; ACK 0x4B sent.
- 'R' -> o_dunit_reset_pc high exactly 1 cycle; 0x4B sent; o_busy falls afterwards.
- 'C' with i_halt rising after 10 enabled cycles -> o_dunit_clk_en high exactly 10 cycles, low in the cycle i_halt is high; dump starts; 256 bytes total; the reg-1 bytes equal model value 0x00000005.
- 'S' with i_halt=1 -> exactly 1 clk_en cycle, then full dump.
- i_tx_done delayed 50 cycles per byte; reset asserted mid-dump at byte 37 -> no new o_tx_start after 37 bytes; all outputs 0 immediately; next 'R' is accepted normally.
- 'L',0x81 followed by 516 bytes -> 128 w_mem pulses (last addr 0x1FC), word 129 not written, ACK sent.
